// File: rtl/led_drv_pkg.sv
// Shared register map, control bit positions and
// reset values for the LED PWM output stage.
package led_drv_pkg;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_DUTY   = 2'd1;
   localparam logic [1:0] ADDR_BLINK  = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam int CTRL_EN    = 0;
   localparam int CTRL_BLINK = 1;
   localparam int CTRL_SYNC  = 2;

   localparam logic [2:0]  CTRL_RST     = 3'b001;
   localparam logic        DUTY_RST_BIT = 1'b1;
   localparam logic [15:0] BLINK_RST    = 16'd0;

endpackage

// File: rtl/led_blink_timer.sv
// Tick prescaler plus half-period counter that
// produces the blink phase for the LED stage.
module led_blink_timer #(
   parameter int TICK_DIV = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        blink_en,
   input  logic [15:0] half_period,
   input  logic        restart,
   output logic        phase
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [15:0]   cnt_q, cnt_d;
   logic          phase_q, phase_d;
   logic          tick;

   assign tick  = (presc_q == TICK_MAX);
   assign phase = phase_q;

   always_comb begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (restart) begin
         presc_d = '0;
         cnt_d   = '0;
         phase_d = 1'b1;
      end else if (!blink_en || half_period == 16'd0) begin
         cnt_d   = '0;
         phase_d = 1'b1;
      end else if (tick) begin
         if (cnt_q == half_period - 16'd1) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q <= '0;
         cnt_q   <= '0;
         phase_q <= 1'b1;
      end else begin
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/led_pwm_driver.sv
// LED output stage: pattern capture, global PWM
// dimming and blink gating behind an Avalon-MM slave.
module led_pwm_driver
   import led_drv_pkg::*;
#(
   parameter int WIDTH    = 10,
   parameter int PWM_BITS = 8,
   parameter int TICK_DIV = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] led_pattern,
   output logic [WIDTH-1:0] led_out
);

   localparam logic [PWM_BITS-1:0] DUTY_INIT = {PWM_BITS{DUTY_RST_BIT}};

   logic [2:0]          ctrl_q, ctrl_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [15:0]         blink_q, blink_d;
   logic [PWM_BITS-1:0] duty_act_q, duty_act_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [WIDTH-1:0]    pattern_q, pattern_d;
   logic [WIDTH-1:0]    led_q, led_d;
   logic                wr, blink_wr, boundary, pwm_on, phase;

   assign wr       = chipselect & ~write_n;
   assign blink_wr = wr & (address == ADDR_BLINK);
   assign boundary = &pwm_cnt_q;
   assign pwm_on   = (&duty_act_q) | (pwm_cnt_q < duty_act_q);
   assign led_out  = led_q;

   led_blink_timer #(
      .TICK_DIV(TICK_DIV)
   ) u_blink (
      .clk        (clk),
      .reset      (reset),
      .blink_en   (ctrl_q[CTRL_BLINK]),
      .half_period(blink_q),
      .restart    (blink_wr),
      .phase      (phase)
   );

   always_comb begin
      ctrl_d  = ctrl_q;
      duty_d  = duty_q;
      blink_d = blink_q;
      if (wr) begin
         case (address)
            ADDR_CTRL:  ctrl_d  = writedata[2:0];
            ADDR_DUTY:  duty_d  = writedata[PWM_BITS-1:0];
            ADDR_BLINK: blink_d = writedata[15:0];
            default:    ;
         endcase
      end
   end

   // Duty and synced pattern only move at the period edge
   always_comb begin
      pwm_cnt_d  = pwm_cnt_q + 1'b1;
      duty_act_d = boundary ? duty_q : duty_act_q;
      pattern_d  = pattern_q;
      if (!ctrl_q[CTRL_SYNC] || boundary)
         pattern_d = led_pattern;
      led_d = pattern_q & {WIDTH{pwm_on & phase & ctrl_q[CTRL_EN]}};
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_CTRL:  readdata[2:0]          = ctrl_q;
         ADDR_DUTY:  readdata[PWM_BITS-1:0] = duty_q;
         ADDR_BLINK: readdata[15:0]         = blink_q;
         default: begin
            readdata[WIDTH-1:0] = led_q;
            readdata[16]        = phase;
            readdata[17]        = |pattern_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q     <= CTRL_RST;
         duty_q     <= DUTY_INIT;
         blink_q    <= BLINK_RST;
         duty_act_q <= DUTY_INIT;
         pwm_cnt_q  <= '0;
         pattern_q  <= '0;
         led_q      <= '0;
      end else begin
         ctrl_q     <= ctrl_d;
         duty_q     <= duty_d;
         blink_q    <= blink_d;
         duty_act_q <= duty_act_d;
         pwm_cnt_q  <= pwm_cnt_d;
         pattern_q  <= pattern_d;
         led_q      <= led_d;
      end
   end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Self-checking bench for led_pwm_driver with a
// cycle-indexed arithmetic reference model.
module tb_led_pwm_driver;

   localparam int W  = 10;
   localparam int PB = 8;
   localparam int TD = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic [W-1:0]  led_pattern;
   logic [W-1:0]  led_out;

   always #5 clk = ~clk;

   led_pwm_driver #(
      .WIDTH   (W),
      .PWM_BITS(PB),
      .TICK_DIV(TD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .led_pattern(led_pattern),
      .led_out    (led_out)
   );

   int ncmp = 0;
   int nbad = 0;

   // model: c = cycles since reset, cb = blink run start,
   // cp = prescaler origin cycle
   int          c = 0;
   int          cb = 0;
   int          cp = 0;
   bit          m_valid = 1'b0;
   logic [2:0]  m_ctrl = 3'b001;
   logic [7:0]  m_duty = 8'hFF;
   logic [7:0]  m_act = 8'hFF;
   logic [15:0] m_blink = 16'd0;
   logic [W-1:0] m_pat = '0;
   logic [W-1:0] m_led = '0;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nbad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int ticks_in(int a, int b, int p);
      if (b < a) return 0;
      return (b - p + 1) / TD - (a - p) / TD;
   endfunction

   function automatic logic m_phase();
      int n;
      n = ticks_in(cb, c - 1, cp);
      if (n == 0) return 1'b1;
      return ((n / int'(m_blink)) % 2) == 0;
   endfunction

   function automatic logic [31:0] exp_rd(logic [1:0] a, logic ph);
      logic [31:0] r;
      r = '0;
      case (a)
         2'd0: r[2:0] = m_ctrl;
         2'd1: r[7:0] = m_duty;
         2'd2: r[15:0] = m_blink;
         default: begin
            r[W-1:0] = m_led;
            r[16] = ph;
            r[17] = |m_pat;
         end
      endcase
      return r;
   endfunction

   task automatic step();
      logic ph, on, bnd;
      #1;
      ph  = m_phase();
      bnd = (c % 256) == 255;
      on  = (m_act == 8'hFF) || ((c % 256) < int'(m_act));
      if (m_valid) check("readdata", readdata, exp_rd(address, ph));
      if (reset) begin
         c = 0; cb = 0; cp = 0;
         m_ctrl = 3'b001; m_duty = 8'hFF; m_act = 8'hFF;
         m_blink = 16'd0; m_pat = '0; m_led = '0;
      end else begin
         m_led = m_pat & {W{on & ph & m_ctrl[0]}};
         if (!m_ctrl[2] || bnd) m_pat = led_pattern;
         if (bnd) m_act = m_duty;
         if (!(m_ctrl[1] && m_blink != 16'd0)) cb = c + 1;
         if (chipselect && !write_n) begin
            case (address)
               2'd0: m_ctrl = writedata[2:0];
               2'd1: m_duty = writedata[7:0];
               2'd2: begin
                  m_blink = writedata[15:0];
                  cb = c + 1;
                  cp = c + 1;
               end
               default: ;
            endcase
         end
         c++;
      end
      @(posedge clk);
      #1;
      check("led_out", 32'(led_out), 32'(m_led));
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic bus_wr(logic [1:0] a, logic [31:0] d);
      address = a; writedata = d;
      chipselect = 1'b1; write_n = 1'b0;
      step();
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
   endtask

   task automatic rd_check(string tag, logic [1:0] a, logic [31:0] exp);
      address = a;
      #1;
      check(tag, readdata, exp);
   endtask

   initial begin
      int hi, chg, viol;
      logic [W-1:0] prev;
      reset = 1'b1; address = '0; chipselect = 1'b0;
      write_n = 1'b1; writedata = '0; led_pattern = '0;
      step();
      m_valid = 1'b1;
      step();
      reset = 1'b0;

      rd_check("rst_ctrl", 2'd0, 32'h1);
      rd_check("rst_duty", 2'd1, 32'hFF);
      rd_check("rst_blink", 2'd2, 32'h0);
      rd_check("rst_status", 2'd3, 32'h0001_0000);

      led_pattern = 10'h155;
      step();
      check("lat1", 32'(led_out), 32'h0);
      step();
      check("lat2", 32'(led_out), 32'h155);
      rd_check("status155", 2'd3, 32'h0003_0155);

      led_pattern = 10'h3FF;
      bus_wr(2'd1, 32'd64);
      idle(300);
      hi = 0;
      for (int i = 0; i < 256; i++) begin
         step();
         hi += int'(led_out[0]);
      end
      check("duty64", 32'(hi), 32'd64);

      bus_wr(2'd1, 32'd0);
      idle(300);
      hi = 0;
      for (int i = 0; i < 256; i++) begin
         step();
         hi += int'(|led_out);
      end
      check("duty0", 32'(hi), 32'd0);

      bus_wr(2'd1, 32'd255);
      idle(300);
      chg = 0;
      prev = led_out;
      for (int i = 0; i < 256; i++) begin
         step();
         if (led_out !== prev) chg++;
         prev = led_out;
      end
      check("duty255_chg", 32'(chg), 32'd0);
      check("duty255_val", 32'(led_out), 32'h3FF);

      bus_wr(2'd0, 32'd3);
      bus_wr(2'd2, 32'd3);
      idle(30);
      hi = 0; chg = 0;
      prev = led_out;
      for (int i = 0; i < 48; i++) begin
         step();
         if (led_out === 10'h3FF) hi++;
         if (led_out !== prev) chg++;
         prev = led_out;
      end
      check("blink_lit", 32'(hi), 32'd24);
      check("blink_edges", 32'(chg), 32'd4);

      bus_wr(2'd0, 32'd5);
      idle(2);
      chg = 0; viol = 0;
      prev = led_out;
      for (int i = 0; i < 600; i++) begin
         led_pattern = W'($urandom_range(1, 1023));
         step();
         if (led_out !== prev) begin
            chg++;
            if ((c % 256) != 1) viol++;
         end
         prev = led_out;
      end
      check("sync_viol", 32'(viol), 32'd0);
      check("sync_chg", 32'(chg >= 2), 32'd1);

      led_pattern = 10'h2F0;
      idle(300);
      bus_wr(2'd0, 32'd0);
      step();
      check("en_off", 32'(led_out), 32'h0);
      bus_wr(2'd3, $urandom);
      rd_check("ro_ctrl", 2'd0, 32'h0);
      rd_check("ro_duty", 2'd1, 32'hFF);
      rd_check("ro_blink", 2'd2, 32'h3);

      led_pattern = 10'h2AA;
      bus_wr(2'd0, 32'd3);
      bus_wr(2'd2, 32'd2);
      idle(37);
      reset = 1'b1;
      address = 2'd1; writedata = 32'h12;
      chipselect = 1'b1; write_n = 1'b0;
      step();
      reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
      check("rst_led", 32'(led_out), 32'h0);
      rd_check("rst2_duty", 2'd1, 32'hFF);
      rd_check("rst2_ctrl", 2'd0, 32'h1);
      rd_check("rst2_blink", 2'd2, 32'h0);
      rd_check("rst2_status", 2'd3, 32'h0001_0000);
      step();
      check("rst_led_hold", 32'(led_out), 32'h0);

      for (int i = 0; i < 4000; i++) begin
         address = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0)
            led_pattern = W'($urandom);
         if ($urandom_range(0, 599) == 0)
            reset = 1'b1;
         if ($urandom_range(0, 11) == 0) begin
            case (address)
               2'd0: writedata = 32'($urandom_range(0, 7));
               2'd1: writedata = $urandom;
               2'd2: writedata = 32'($urandom_range(0, 4));
               default: writedata = $urandom;
            endcase
            chipselect = 1'b1; write_n = 1'b0;
         end
         step();
         reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end

endmodule
